// File: rtl/interp_pkg.sv
// Shared definitions for the R-fold interpolator (and its decimator sibling).
package interp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_R          = 5;
  localparam int unsigned DEF_DATA_WIDTH = 22;

  // Phase counter width; never below one bit.
  function automatic int unsigned phase_width(input int unsigned r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/interpolate_r_if.sv
// Sample handshake between the waveform source and the interpolator.
interface interpolate_r_if
  import interp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic signed [DATA_WIDTH-1:0] din;
  logic                         din_valid;
  logic                         din_ready;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         underrun;

  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, underrun
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, underrun
  );

endinterface

// File: rtl/interp_phase_counter.sv
// Modulo-R phase counter with synchronous restart and terminal-count flag.
module interp_phase_counter
  import interp_pkg::*;
#(
  parameter int unsigned R = DEF_R
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        en,
  output logic [phase_width(R)-1:0]   c,
  output logic                        last
);

  localparam int unsigned PW = phase_width(R);
  localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);

  assign last = (c == LAST_PHASE);

  // Restart wins over advance; wrap to zero after the terminal phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
    end else if (start) begin
      c <= '0;
    end else if (en) begin
      c <= last ? '0 : PW'(c + PW'(1));
    end
  end

endmodule

// File: rtl/interpolate_r.sv
// R-fold interpolator: one sample in, R samples out (sample then zeros).
// Build option INTERP_HOLD_EN: repeat the sample for all R phases instead.
module interpolate_r
  import interp_pkg::*;
#(
  parameter int unsigned R          = DEF_R,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  interpolate_r_if.slave  bus
);

  localparam int unsigned PW = phase_width(R);
  localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);

  state_t                       state, state_n;
  logic [PW-1:0]                c;
  logic                         last;
  logic                         accept;
  logic                         run_cont;
  logic signed [DATA_WIDTH-1:0] hold, hold_n;
  logic signed [DATA_WIDTH-1:0] dout_n;
  logic                         dout_valid_n;
  logic                         underrun_n;

  interp_phase_counter #(.R(R)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .en    (state == RUN),
    .c     (c),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state: stay in RUN while samples keep arriving on the last phase.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (last && !accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode: ready strobe plus next values of the registered outputs.
  always_comb begin
    bus.din_ready = (state == IDLE) || (c == LAST_PHASE);
    accept        = bus.din_valid && bus.din_ready;
    run_cont      = (state == RUN) && !last;
    hold_n        = accept ? bus.din : hold;
    dout_valid_n  = accept || run_cont;
    underrun_n    = (state == RUN) && last && !accept;
`ifdef INTERP_HOLD_EN
    dout_n        = accept ? hold_n : (run_cont ? hold : '0);
`else
    dout_n        = accept ? hold_n : '0;
`endif
  end

  // Hold register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold           <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.underrun   <= 1'b0;
    end else begin
      hold           <= hold_n;
      bus.dout       <= dout_n;
      bus.dout_valid <= dout_valid_n;
      bus.underrun   <= underrun_n;
    end
  end

endmodule

// File: tb/tb_interpolate_r.sv
// Self-checking bench for interpolate_r (R=5, 22-bit samples).
module tb_interpolate_r;

  localparam int R  = 5;
  localparam int DW = 22;
`ifdef INTERP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  interpolate_r_if #(.DATA_WIDTH(DW)) ifc ();

  interpolate_r #(.R(R), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int und_cnt  = 0;
  int q_out[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining output cycles of the current burst and its sample.
  int m_rem    = 0;
  int m_sample = 0;
  bit m_und    = 1'b0;

  function automatic bit m_ready();
    return m_rem <= 1;
  endfunction

  function automatic int m_dout();
    if (m_rem == 0) return 0;
    if (R - m_rem == 0) return m_sample;
    return HOLD ? m_sample : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem    = 0;
      m_sample = 0;
      m_und    = 1'b0;
    end else begin
      bit acc;
      acc   = ifc.din_valid && m_ready();
      m_und = (m_rem == 1) && !acc;
      if (acc) begin
        m_rem    = R;
        m_sample = int'(ifc.din);
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
  end

  // Per-cycle compare against the model, plus output capture.
  always @(negedge clk) begin
    chk("dout_valid", int'(ifc.dout_valid), int'(m_rem > 0));
    chk("underrun", int'(ifc.underrun), int'(m_und));
    chk("din_ready", int'(ifc.din_ready), int'(m_ready()));
    if (m_rem > 0) chk("dout", int'(ifc.dout), m_dout());
    if (ifc.dout_valid) q_out.push_back(int'(ifc.dout));
    if (ifc.underrun) und_cnt++;
  end

  // Hand-written expected burst for sample s.
  function automatic int ph(input int s, input int k);
    return (k == 0) ? s : (HOLD ? s : 0);
  endfunction

  task automatic check_q(input string name, input int exp[$]);
    chk({name, "_len"}, q_out.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_out.size(); i++)
      chk($sformatf("%s[%0d]", name, i), q_out[i], exp[i]);
    q_out.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Present v and wait (bounded) until the model says it was taken.
  task automatic send(input int v);
    bit r;
    ifc.din       = DW'(v);
    ifc.din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = m_ready();
      @(posedge clk);
      #2;
      if (r) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  initial begin
    int exp[$];
    int u0;
    ifc.din       = '0;
    ifc.din_valid = 1'b0;

    // Reset values.
    #1;
    chk("rst_dout", int'(ifc.dout), 0);
    chk("rst_valid", int'(ifc.dout_valid), 0);
    chk("rst_ready", int'(ifc.din_ready), 1);
    chk("rst_underrun", int'(ifc.underrun), 0);
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // Single sample.
    u0 = und_cnt;
    send(1000);
    ifc.din_valid = 1'b0;
    cycles(R + 3);
    exp = '{};
    for (int k = 0; k < R; k++) exp.push_back(ph(1000, k));
    check_q("single", exp);
    chk("single_underrun_cnt", und_cnt - u0, 1);

    // Back-to-back stream, gap-free.
    u0 = und_cnt;
    send(-5);
    send(7);
    send(-9);
    ifc.din_valid = 1'b0;
    cycles(R + 3);
    exp = '{};
    for (int k = 0; k < R; k++) exp.push_back(ph(-5, k));
    for (int k = 0; k < R; k++) exp.push_back(ph(7, k));
    for (int k = 0; k < R; k++) exp.push_back(ph(-9, k));
    check_q("b2b", exp);
    chk("b2b_underrun_cnt", und_cnt - u0, 1);

    // Backpressure: din wiggles while not ready, final value is taken.
    send(10);
    ifc.din_valid = 1'b0;
    cycles(1);
    ifc.din       = DW'(42);
    ifc.din_valid = 1'b1;
    cycles(1);
    ifc.din       = DW'(43);
    cycles(1);
    ifc.din       = DW'(43);
    cycles(1);
    ifc.din       = DW'(42);
    cycles(1);
    ifc.din_valid = 1'b0;
    cycles(R + 3);
    exp = '{};
    for (int k = 0; k < R; k++) exp.push_back(ph(10, k));
    for (int k = 0; k < R; k++) exp.push_back(ph(42, k));
    check_q("bp", exp);

    // Extremes reproduced bit-exact.
    send(-2097152);
    send(2097151);
    ifc.din_valid = 1'b0;
    cycles(R + 3);
    exp = '{};
    for (int k = 0; k < R; k++) exp.push_back(ph(-2097152, k));
    for (int k = 0; k < R; k++) exp.push_back(ph(2097151, k));
    check_q("ext", exp);

    // Hold-mode style sample.
    send(300);
    ifc.din_valid = 1'b0;
    cycles(R + 3);
    exp = '{};
    for (int k = 0; k < R; k++) exp.push_back(ph(300, k));
    check_q("s300", exp);

    // Reset mid-burst at phase 2, then idle without underrun.
    send(77);
    ifc.din_valid = 1'b0;
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dout", int'(ifc.dout), 0);
    chk("midrst_valid", int'(ifc.dout_valid), 0);
    chk("midrst_ready", int'(ifc.din_ready), 1);
    chk("midrst_underrun", int'(ifc.underrun), 0);
    cycles(1);
    rst = 1'b0;
    q_out.delete();
    u0 = und_cnt;
    cycles(20);
    chk("idle_underrun_cnt", und_cnt - u0, 0);
    chk("idle_no_output", q_out.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
